// File: rtl/spi_master_ctrl_pkg.sv
// spi_pkg: shared types and helpers for the SPI master transfer controller.
// Holds the controller state encoding, the four SPI mode codes ({CPOL,CPHA})
// and the chip-select index width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Width of the chip-select index; a single CS still gets a 1-bit select.
    function automatic int cs_sel_w(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: register-side and pin-side signals of the SPI master.
// Macro SPI_LSB_FIRST_EN adds the LSB_FIRST control input.
interface spi_master_ctrl_if
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 2
);
    localparam int CS_W = cs_sel_w(NUM_CS);

    logic              EN;
    logic              CPOL;
    logic              CPHA;
    logic [DIV_W-1:0]  DIV;
    logic [CS_W-1:0]   CS_SEL;
    logic              WRITE;
    logic [DATA_W-1:0] WDATA;
    logic              READ;
    logic [DATA_W-1:0] RDATA;
    logic              TX_FULL;
    logic              RX_FULL;
    logic              BUSY;
    logic              DONE;
    logic              OVERRUN;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [NUM_CS-1:0] CS_N;
`ifdef SPI_LSB_FIRST_EN
    logic              LSB_FIRST;
`endif

    modport master (
        input  EN, CPOL, CPHA, DIV, CS_SEL, WRITE, WDATA, READ, MISO,
`ifdef SPI_LSB_FIRST_EN
        input  LSB_FIRST,
`endif
        output RDATA, TX_FULL, RX_FULL, BUSY, DONE, OVERRUN, SCLK, MOSI, CS_N
    );

    modport slave (
        output EN, CPOL, CPHA, DIV, CS_SEL, WRITE, WDATA, READ, MISO,
`ifdef SPI_LSB_FIRST_EN
        output LSB_FIRST,
`endif
        input  RDATA, TX_FULL, RX_FULL, BUSY, DONE, OVERRUN, SCLK, MOSI, CS_N
    );

endinterface

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: half-period timer. Counts DIV..0 while enabled and pulses
// tick on the zero count; held at the reload value while disabled so the
// first half-period after enable is a full DIV+1 cycles.
module spi_clk_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    // Down-counter, reloaded on tick or while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (!en || cnt == '0) cnt <= div;
        else                       cnt <= cnt - 1'b1;
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: parametrised SPI master with single-entry TX/RX buffers,
// all four CPOL/CPHA modes, multiple chip selects and CS-held back-to-back
// words. Macro SPI_LSB_FIRST_EN enables LSB-first shifting via LSB_FIRST.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 2
) (
    input logic               CLK,
    input logic               CLR,
    spi_master_ctrl_if.master bus
);
    localparam int CS_W   = cs_sel_w(NUM_CS);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] tx_buf, tx_sh, rx_sh, rdata;
    logic              tx_full, rx_full, done, overrun, sclk;
    logic [NUM_CS-1:0] cs_n;
    logic [EDGE_W-1:0] edge_cnt;
    logic              cpha_lat;
    logic [DIV_W-1:0]  div_lat;
    logic [CS_W-1:0]   cs_lat;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_lat;
`else
    localparam logic   lsb_lat = 1'b0;
`endif

    logic tick, start, reload, word_done, sample_edge, shift_edge;
    logic [DIV_W-1:0] tick_div;

    assign start     = (state == IDLE) && bus.EN && tx_full;
    assign word_done = (state == TRAIL) && tick;
    assign reload    = word_done && bus.EN && tx_full && (bus.CS_SEL == cs_lat);
    // Sample on odd edges for CPHA=0, even edges for CPHA=1; shift on the
    // other parity. With CPHA=1 the first leading edge only presents the MSB
    // that is already on MOSI, so it does not shift.
    assign sample_edge = (state == SHIFT) && tick && (edge_cnt[0] == cpha_lat);
    assign shift_edge  = (state == SHIFT) && tick && (edge_cnt[0] != cpha_lat)
                         && !(cpha_lat && edge_cnt == '0);
    // The timer loads the live DIV while idle so the LEAD phase uses the
    // value latched at word start.
    assign tick_div = (state == IDLE) ? bus.DIV : div_lat;

    spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (CLK),
        .rst  (CLR),
        .en   (state != IDLE),
        .div  (tick_div),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; TRAIL either chains into the next word or goes idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    if (tick) state_nxt = SHIFT;
            SHIFT:   if (tick && edge_cnt == LAST_EDGE) state_nxt = TRAIL;
            TRAIL:   if (tick) state_nxt = reload ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // TX holding buffer: accepts a write only when empty, empties on load.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else if (start || reload) begin
            tx_full <= 1'b0;
        end else if (bus.WRITE && !tx_full) begin
            tx_full <= 1'b1;
            tx_buf  <= bus.WDATA;
        end
    end

    // Shift registers and per-word configuration. DIV and CS stay fixed for
    // a CS-held burst; CPHA and bit order are re-latched at every word.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpha_lat <= 1'b0;
            div_lat  <= '0;
            cs_lat   <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_lat  <= 1'b0;
`endif
        end else if (start || reload) begin
            tx_sh    <= tx_buf;
            cpha_lat <= bus.CPHA;
`ifdef SPI_LSB_FIRST_EN
            lsb_lat  <= bus.LSB_FIRST;
`endif
            if (start) begin
                div_lat <= bus.DIV;
                cs_lat  <= bus.CS_SEL;
            end
        end else begin
            if (shift_edge)
                tx_sh <= lsb_lat ? (tx_sh >> 1) : (tx_sh << 1);
            if (sample_edge)
                rx_sh <= lsb_lat ? {bus.MISO, rx_sh[DATA_W-1:1]}
                                 : {rx_sh[DATA_W-2:0], bus.MISO};
        end
    end

    // SCLK, chip selects and edge counter.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sclk     <= 1'b0;
            cs_n     <= '1;
            edge_cnt <= '0;
        end else begin
            if (state == IDLE)
                sclk <= bus.CPOL;
            else if (state == SHIFT && tick)
                sclk <= ~sclk;
            if (start)
                cs_n <= ~(NUM_CS'(1) << bus.CS_SEL);
            else if (word_done && !reload)
                cs_n <= '1;
            if (state == SHIFT && tick)
                edge_cnt <= (edge_cnt == LAST_EDGE) ? '0 : edge_cnt + 1'b1;
        end
    end

    // RX holding buffer, completion pulse and sticky overrun.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            rdata   <= '0;
            rx_full <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= word_done;
            if (word_done) begin
                if (!rx_full || bus.READ) begin
                    rdata   <= rx_sh;
                    rx_full <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
                if (bus.READ && rx_full) overrun <= 1'b0;
            end else if (bus.READ && rx_full) begin
                rx_full <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    assign bus.RDATA   = rdata;
    assign bus.TX_FULL = tx_full;
    assign bus.RX_FULL = rx_full;
    assign bus.BUSY    = (state != IDLE);
    assign bus.DONE    = done;
    assign bus.OVERRUN = overrun;
    assign bus.SCLK    = sclk;
    assign bus.MOSI    = (state == IDLE) ? 1'b0
                       : (lsb_lat ? tx_sh[0] : tx_sh[DATA_W-1]);
    assign bus.CS_N    = cs_n;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl (DATA_W=8, NUM_CS=2).
// A pin-level slave model either loops MOSI back to MISO or returns a fixed
// word according to CPHA, and captures MOSI on the slave's sampling edges.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    spi_master_ctrl_if #(.DATA_W(8), .DIV_W(8), .NUM_CS(2)) bus ();

    spi_master_ctrl #(.DATA_W(8), .DIV_W(8), .NUM_CS(2)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Slave model state
    logic       loopback   = 1'b1;
    logic       cpha_tb    = 1'b0;
    logic [7:0] slave_word = 8'h00;
    logic       cs_chk     = 1'b0;
    int         edges      = 0;
    int         rises      = 0;
    int         cs_bad     = 0;
    logic       sclk_q     = 1'b0;
    logic [7:0] mosi_cap   = 8'h00;

    function automatic logic slave_out(input int e, input logic ph, input logic [7:0] w);
        int k;
        int idx;
        k = e % 16;
        if (!ph) idx = 7 - k / 2;
        else     idx = (k == 0) ? 7 : 7 - (k - 1) / 2;
        return w[idx];
    endfunction

    assign bus.MISO = loopback ? bus.MOSI : slave_out(edges, cpha_tb, slave_word);

    always @(negedge clk) begin
        if (&bus.CS_N) edges <= 0;
        else if (bus.SCLK !== sclk_q) begin
            edges <= edges + 1;
            if ((edges % 2) == int'(cpha_tb)) mosi_cap <= {mosi_cap[6:0], bus.MOSI};
        end
        if (bus.SCLK === 1'b1 && sclk_q === 1'b0 && !(&bus.CS_N)) rises <= rises + 1;
        if (bus.BUSY === 1'b1 && bus.CS_N[cs_chk] !== 1'b0) cs_bad <= cs_bad + 1;
        sclk_q <= bus.SCLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        bus.WRITE = 1'b1;
        bus.WDATA = d;
        @(negedge clk);
        bus.WRITE = 1'b0;
    endtask

    task automatic do_read();
        @(negedge clk);
        bus.READ = 1'b1;
        @(negedge clk);
        bus.READ = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (bus.DONE === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.EN = 1'b0; bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.DIV = 8'd1;
        bus.CS_SEL = 1'b0; bus.WRITE = 1'b0; bus.WDATA = 8'h00; bus.READ = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        bus.LSB_FIRST = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.SCLK !== 1'b0) begin n_err++; $display("FAIL rst_sclk got %b want 0", bus.SCLK); end
        n_cmp++; if (bus.MOSI !== 1'b0) begin n_err++; $display("FAIL rst_mosi got %b want 0", bus.MOSI); end
        n_cmp++; if (bus.CS_N !== 2'b11) begin n_err++; $display("FAIL rst_cs_n got %b want 11", bus.CS_N); end
        n_cmp++; if ({bus.TX_FULL, bus.RX_FULL, bus.BUSY, bus.DONE, bus.OVERRUN} !== 5'b0) begin
            n_err++; $display("FAIL rst_flags got %b want 00000",
                              {bus.TX_FULL, bus.RX_FULL, bus.BUSY, bus.DONE, bus.OVERRUN});
        end
        n_cmp++; if (bus.RDATA !== 8'h00) begin n_err++; $display("FAIL rst_rdata got %h want 00", bus.RDATA); end
    endtask

    task automatic test_mode0_loopback();
        int n, r0, c0;
        loopback = 1'b1; cpha_tb = 1'b0; cs_chk = 1'b0;
        bus.EN = 1'b1; bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.DIV = 8'd1; bus.CS_SEL = 1'b0;
        r0 = rises; c0 = cs_bad;
        write_word(8'hA5);
        wait_done(200, n);
        n_cmp++; if (n != 37) begin n_err++; $display("FAIL m0_latency got %0d want 37", n); end
        n_cmp++; if (bus.RDATA !== 8'hA5) begin n_err++; $display("FAIL m0_rdata got %h want a5", bus.RDATA); end
        n_cmp++; if (bus.RX_FULL !== 1'b1) begin n_err++; $display("FAIL m0_rx_full got %b want 1", bus.RX_FULL); end
        n_cmp++; if (mosi_cap !== 8'hA5) begin n_err++; $display("FAIL m0_mosi got %h want a5", mosi_cap); end
        n_cmp++; if (rises - r0 != 8) begin n_err++; $display("FAIL m0_sclk_rises got %0d want 8", rises - r0); end
        n_cmp++; if (cs_bad - c0 != 0) begin n_err++; $display("FAIL m0_cs0_low got %0d violations want 0", cs_bad - c0); end
        @(posedge clk); #1;
        n_cmp++; if (bus.DONE !== 1'b0) begin n_err++; $display("FAIL m0_done_pulse got %b want 0", bus.DONE); end
        n_cmp++; if (bus.CS_N !== 2'b11) begin n_err++; $display("FAIL m0_cs_release got %b want 11", bus.CS_N); end
        do_read();
    endtask

    task automatic test_modes();
        logic [1:0] modes [3];
        int n;
        modes[0] = MODE1; modes[1] = MODE2; modes[2] = MODE3;
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            loopback = 1'b0; slave_word = 8'hC3; cpha_tb = modes[m][0];
            bus.CPOL = modes[m][1]; bus.CPHA = modes[m][0];
            repeat (4) @(negedge clk);
            n_cmp++; if (bus.SCLK !== modes[m][1]) begin n_err++; $display("FAIL mode%0d_idle_before got %b want %b", m + 1, bus.SCLK, modes[m][1]); end
            write_word(8'h3C);
            wait_done(200, n);
            n_cmp++; if (n != 37) begin n_err++; $display("FAIL mode%0d_latency got %0d want 37", m + 1, n); end
            n_cmp++; if (bus.RDATA !== 8'hC3) begin n_err++; $display("FAIL mode%0d_rdata got %h want c3", m + 1, bus.RDATA); end
            n_cmp++; if (mosi_cap !== 8'h3C) begin n_err++; $display("FAIL mode%0d_mosi got %h want 3c", m + 1, mosi_cap); end
            n_cmp++; if (bus.SCLK !== modes[m][1]) begin n_err++; $display("FAIL mode%0d_idle_after got %b want %b", m + 1, bus.SCLK, modes[m][1]); end
            do_read();
        end
        @(negedge clk);
        bus.CPOL = 1'b0; bus.CPHA = 1'b0; cpha_tb = 1'b0; loopback = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n1, n2, c0;
        @(negedge clk);
        bus.CS_SEL = 1'b1; cs_chk = 1'b1; loopback = 1'b1; cpha_tb = 1'b0;
        c0 = cs_bad;
        write_word(8'h96);
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL b2b_busy_mid got %b want 1", bus.BUSY); end
        write_word(8'h69);
        wait_done(200, n1);
        n_cmp++; if (n1 < 0) begin n_err++; $display("FAIL b2b_done1 got timeout want pulse"); end
        n_cmp++; if (bus.RDATA !== 8'h96) begin n_err++; $display("FAIL b2b_rdata1 got %h want 96", bus.RDATA); end
        n_cmp++; if (bus.CS_N !== 2'b01) begin n_err++; $display("FAIL b2b_cs_held got %b want 01", bus.CS_N); end
        bus.READ = 1'b1;
        @(posedge clk); #1;
        bus.READ = 1'b0;
        n_cmp++; if (bus.RX_FULL !== 1'b0) begin n_err++; $display("FAIL b2b_read_clear got %b want 0", bus.RX_FULL); end
        wait_done(200, n2);
        // 17 half-periods of 2 cycles between pulses; one is consumed by the read
        n_cmp++; if (n2 != 33) begin n_err++; $display("FAIL b2b_done_spacing got %0d want 33", n2); end
        n_cmp++; if (bus.RDATA !== 8'h69) begin n_err++; $display("FAIL b2b_rdata2 got %h want 69", bus.RDATA); end
        n_cmp++; if (cs_bad - c0 != 0) begin n_err++; $display("FAIL b2b_cs1_low got %0d violations want 0", cs_bad - c0); end
        do_read();
        @(negedge clk);
        bus.CS_SEL = 1'b0; cs_chk = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        write_word(8'h5A);
        wait_done(200, n);
        n_cmp++; if (n < 0) begin n_err++; $display("FAIL ovr_done1 got timeout want pulse"); end
        write_word(8'h0F);
        wait_done(200, n);
        n_cmp++; if (bus.RDATA !== 8'h5A) begin n_err++; $display("FAIL ovr_rdata_kept got %h want 5a", bus.RDATA); end
        n_cmp++; if (bus.OVERRUN !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b want 1", bus.OVERRUN); end
        n_cmp++; if (bus.RX_FULL !== 1'b1) begin n_err++; $display("FAIL ovr_rx_full got %b want 1", bus.RX_FULL); end
        do_read();
        n_cmp++; if ({bus.RX_FULL, bus.OVERRUN} !== 2'b00) begin n_err++; $display("FAIL ovr_read_clear got %b want 00", {bus.RX_FULL, bus.OVERRUN}); end
    endtask

    task automatic test_clr_mid();
        @(negedge clk);
        bus.CPOL = 1'b1;
        repeat (3) @(negedge clk);
        write_word(8'h81);
        repeat (12) @(negedge clk);
        write_word(8'h42);
        @(negedge clk);
        n_cmp++; if ({bus.BUSY, bus.TX_FULL, bus.SCLK} !== 3'b111) begin
            n_err++; $display("FAIL clr_pre got busy/tx_full/sclk=%b want 111", {bus.BUSY, bus.TX_FULL, bus.SCLK});
        end
        clr = 1'b1;
        #1;
        n_cmp++; if (bus.CS_N !== 2'b11) begin n_err++; $display("FAIL clr_cs_n got %b want 11", bus.CS_N); end
        n_cmp++; if (bus.SCLK !== 1'b0) begin n_err++; $display("FAIL clr_sclk got %b want 0", bus.SCLK); end
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL clr_busy got %b want 0", bus.BUSY); end
        n_cmp++; if (bus.TX_FULL !== 1'b0) begin n_err++; $display("FAIL clr_tx_full got %b want 0", bus.TX_FULL); end
        @(negedge clk);
        bus.CPOL = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_full_ignore();
        int n;
        @(negedge clk);
        bus.EN = 1'b0; loopback = 1'b1; cpha_tb = 1'b0;
        write_word(8'h11);
        write_word(8'h22);
        n_cmp++; if ({bus.TX_FULL, bus.BUSY} !== 2'b10) begin n_err++; $display("FAIL txf_hold got tx_full/busy=%b want 10", {bus.TX_FULL, bus.BUSY}); end
        bus.EN = 1'b1;
        wait_done(200, n);
        n_cmp++; if (bus.RDATA !== 8'h11) begin n_err++; $display("FAIL txf_rdata got %h want 11", bus.RDATA); end
        n_cmp++; if (mosi_cap !== 8'h11) begin n_err++; $display("FAIL txf_mosi got %h want 11", mosi_cap); end
        n_cmp++; if (bus.TX_FULL !== 1'b0) begin n_err++; $display("FAIL txf_dropped got %b want 0", bus.TX_FULL); end
        do_read();
`ifdef SPI_LSB_FIRST_EN
        bus.LSB_FIRST = 1'b1;
        write_word(8'h01);
        wait_done(200, n);
        n_cmp++; if (mosi_cap !== 8'h80) begin n_err++; $display("FAIL lsb_mosi_order got %h want 80", mosi_cap); end
        n_cmp++; if (bus.RDATA !== 8'h01) begin n_err++; $display("FAIL lsb_rdata got %h want 01", bus.RDATA); end
        do_read();
        bus.LSB_FIRST = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_modes();
        test_back_to_back();
        test_overrun();
        test_clr_mid();
        test_tx_full_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
